// File: rtl/insa_trace_buf.sv
// rtl/insa_trace_buf.sv - circular trace buffer with oldest/newest relative reads and crash handshake
module insa_trace_buf #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_valid_i,
    input  logic [31:0]             wr_data_i,
    input  logic [IDX_W-1:0]        rd_index_i,
    output logic [31:0]             rd_first_o,
    output logic [31:0]             rd_last_o,
    output logic                    data_in_buffer_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    overflow_o,
    input  logic                    rst_buf_i,
    input  logic                    en_crash_i,
    output logic                    crash_req_o,
    input  logic                    crash_ack_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CMP_W = (IDX_W > CNT_W) ? IDX_W : CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              mem_we;
    logic [31:0]       mem_q [DEPTH];

    logic              full;
    logic              idx_valid;
    logic [PTR_W-1:0]  idx_lo;
    logic [PTR_W-1:0]  first_addr;
    logic [PTR_W-1:0]  last_addr;

    assign full = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        if (rst_buf_i) begin
            state_d    = ST_IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (wr_valid_i) begin
                        if (!full) begin
                            mem_we   = 1'b1;
                            wr_ptr_d = wr_ptr_q + PTR_W'(1);
                            count_d  = count_q + CNT_W'(1);
                        end else if (!en_crash_i) begin
                            // Overwrite the oldest entry: both pointers advance together.
                            mem_we     = 1'b1;
                            wr_ptr_d   = wr_ptr_q + PTR_W'(1);
                            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                            overflow_d = 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (crash_ack_i) begin
                        state_d = ST_HALT;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately unreset; invalid indices are masked on the read side.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign idx_valid  = (CMP_W'(rd_index_i) < CMP_W'(count_q));
    assign idx_lo     = PTR_W'(rd_index_i);
    assign first_addr = rd_ptr_q + idx_lo;
    assign last_addr  = wr_ptr_q - idx_lo - PTR_W'(1);

    assign rd_first_o       = idx_valid ? mem_q[first_addr] : 32'h0;
    assign rd_last_o        = idx_valid ? mem_q[last_addr]  : 32'h0;
    assign data_in_buffer_o = (count_q != '0);
    assign count_o          = count_q;
    assign overflow_o       = overflow_q;
    assign crash_req_o      = (state_q == ST_REQ);

endmodule

// File: tb/tb_insa_trace_buf.sv
// tb/tb_insa_trace_buf.sv - directed self-checking bench for insa_trace_buf
module tb_insa_trace_buf;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [19:0] rd_index;
    logic [31:0] rd_first;
    logic [31:0] rd_last;
    logic        dib;
    logic [4:0]  count;
    logic        ovf;
    logic        rst_buf;
    logic        en_crash;
    logic        crash_req;
    logic        crash_ack;

    int n_total = 0;
    int n_pass  = 0;

    insa_trace_buf #(.DEPTH(16), .IDX_W(20)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .wr_valid_i       (wr_valid),
        .wr_data_i        (wr_data),
        .rd_index_i       (rd_index),
        .rd_first_o       (rd_first),
        .rd_last_o        (rd_last),
        .data_in_buffer_o (dib),
        .count_o          (count),
        .overflow_o       (ovf),
        .rst_buf_i        (rst_buf),
        .en_crash_i       (en_crash),
        .crash_req_o      (crash_req),
        .crash_ack_i      (crash_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_buf;
        logic        wr_valid;
        logic [31:0] wr_data;
        logic [19:0] idx;
        logic [4:0]  exp_count;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic clear_buf();
        rst_buf = 1'b1;
        tick();
        rst_buf = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_index = '0;
        rst_buf = 1'b0; en_crash = 1'b0; crash_ack = 1'b0;

        // Columns: rst_buf, wr_valid, data, idx, count, first, last, overflow (sampled before the edge)
        vecs[0] = '{1'b0, 1'b1, 32'hA0, 20'h0,     5'd0, 32'h0,  32'h0,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'hA1, 20'h0,     5'd1, 32'hA0, 32'hA0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 32'hA2, 20'h0,     5'd2, 32'hA0, 32'hA1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 32'h0,  20'h0,     5'd3, 32'hA0, 32'hA2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 32'h0,  20'h2,     5'd3, 32'hA2, 32'hA0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 32'h0,  20'h3,     5'd3, 32'h0,  32'h0,  1'b0};
        vecs[6] = '{1'b0, 1'b0, 32'h0,  20'h10000, 5'd3, 32'h0,  32'h0,  1'b0};
        vecs[7] = '{1'b0, 1'b0, 32'h0,  20'h1,     5'd3, 32'hA1, 32'hA1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 32'hEE, 20'h0,     5'd3, 32'hA0, 32'hA2, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 32'h0,  20'h0,     5'd0, 32'h0,  32'h0,  1'b0};

        #1;
        chk("reset_count", count, 5'd0);
        chk("reset_ovf", ovf, 1'b0);
        chk("reset_req", crash_req, 1'b0);
        chk("reset_dib", dib, 1'b0);
        chk("reset_first", rd_first, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            rst_buf  = vecs[i].rst_buf;
            wr_valid = vecs[i].wr_valid;
            wr_data  = vecs[i].wr_data;
            rd_index = vecs[i].idx;
            #1;
            chk($sformatf("v%0d_count", i), count, vecs[i].exp_count);
            chk($sformatf("v%0d_first", i), rd_first, vecs[i].exp_first);
            chk($sformatf("v%0d_last", i), rd_last, vecs[i].exp_last);
            chk($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
            chk($sformatf("v%0d_dib", i), dib, vecs[i].exp_count != 0);
            tick();
        end
        rst_buf = 1'b0; wr_valid = 1'b0; rd_index = '0;

        // Overwrite-oldest mode: 18 pushes into a 16-deep buffer
        for (int i = 0; i < 16; i++) push(i);
        chk("full_count", count, 5'd16);
        chk("full_no_ovf", ovf, 1'b0);
        push(16);
        push(17);
        chk("ow_count", count, 5'd16);
        chk("ow_ovf", ovf, 1'b1);
        chk("ow_first0", rd_first, 32'd2);
        chk("ow_last0", rd_last, 32'd17);
        rd_index = 20'd15;
        #1;
        chk("ow_first15", rd_first, 32'd17);
        chk("ow_last15", rd_last, 32'd2);
        rd_index = 20'd16;
        #1;
        chk("ow_idx16", rd_first, 32'h0);
        rd_index = '0;
        clear_buf();
        chk("clr_ovf", ovf, 1'b0);

        // Crash handshake
        en_crash = 1'b1;
        for (int i = 0; i < 16; i++) push(32'h100 + i);
        chk("cr_req_idle", crash_req, 1'b0);
        push(32'hDEAD);
        chk("cr_req_set", crash_req, 1'b1);
        chk("cr_ovf", ovf, 1'b1);
        chk("cr_count", count, 5'd16);
        chk("cr_last0", rd_last, 32'h10F);
        en_crash = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("cr_hold%0d", i), crash_req, 1'b1);
        end
        crash_ack = 1'b1;
        tick();
        crash_ack = 1'b0;
        chk("halt_req", crash_req, 1'b0);
        push(32'hBEEF);
        push(32'hBEF0);
        crash_ack = 1'b1;
        tick();
        crash_ack = 1'b0;
        chk("halt_req_ack", crash_req, 1'b0);
        chk("halt_count", count, 5'd16);
        chk("halt_last0", rd_last, 32'h10F);
        chk("halt_first0", rd_first, 32'h100);

        // RSTBUF in HALT with a simultaneous push
        rst_buf = 1'b1; wr_valid = 1'b1; wr_data = 32'h55;
        tick();
        rst_buf = 1'b0; wr_valid = 1'b0;
        chk("rb_count", count, 5'd0);
        chk("rb_dib", dib, 1'b0);
        chk("rb_ovf", ovf, 1'b0);
        chk("rb_last_empty", rd_last, 32'h0);
        wr_valid = 1'b1; wr_data = 32'h66;
        #1;
        chk("same_cycle_last", rd_last, 32'h0);
        tick();
        wr_valid = 1'b0;
        chk("next_cycle_last", rd_last, 32'h66);
        chk("next_cycle_first", rd_first, 32'h66);
        chk("rb_count1", count, 5'd1);
        wr_valid = 1'b1; wr_data = 32'h67;
        #1;
        chk("n_old_last", rd_last, 32'h66);
        tick();
        wr_valid = 1'b0;
        chk("n1_new_last", rd_last, 32'h67);

        // Asynchronous reset while requesting
        en_crash = 1'b1;
        for (int i = 0; i < 15; i++) push(32'h200 + i);
        push(32'h300);
        chk("ar_req_before", crash_req, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_req", crash_req, 1'b0);
        chk("ar_count", count, 5'd0);
        chk("ar_ovf", ovf, 1'b0);
        chk("ar_dib", dib, 1'b0);
        tick();
        rst_n = 1'b1;
        en_crash = 1'b0;
        push(32'h77);
        chk("ar_after_last", rd_last, 32'h77);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
